// File: rtl/risc16_reg_file.sv
// -----------------------------------------------------------------------------
// risc16_reg_file
//   General-purpose register file for the mini-RISC16 datapath.
//   Two combinational read ports drive the ALU operand buses, and one
//   synchronous write port takes the writeback result. Register 0 always
//   reads as zero.
//
// Optional build macro:
//   REGFILE_BYPASS_EN - when defined, a write in flight is forwarded
//                       combinationally to any read port addressing the same
//                       (non-zero) register.
//
// Ports:
//   gclk       in   1               system clock, rising-edge active
//   PowerOn    in   1               asynchronous active-low reset
//   AddrReadA  in   REG_ADDR_WIDTH  read port A register index
//   AddrReadB  in   REG_ADDR_WIDTH  read port B register index
//   AddrWrite  in   REG_ADDR_WIDTH  write port register index
//   WriteEn    in   1               1 = write on the next rising gclk
//   Write      in   WORD_WIDTH      write data
//   ReadA      out  WORD_WIDTH      reg[AddrReadA], combinational
//   ReadB      out  WORD_WIDTH      reg[AddrReadB], combinational
// -----------------------------------------------------------------------------
module risc16_reg_file #(
  parameter int WORD_WIDTH     = 16,
  parameter int REG_ADDR_WIDTH = 3
) (
  input  logic                      gclk,
  input  logic                      PowerOn,
  input  logic [REG_ADDR_WIDTH-1:0] AddrReadA,
  input  logic [REG_ADDR_WIDTH-1:0] AddrReadB,
  input  logic [REG_ADDR_WIDTH-1:0] AddrWrite,
  input  logic                      WriteEn,
  input  logic [WORD_WIDTH-1:0]     Write,
  output logic [WORD_WIDTH-1:0]     ReadA,
  output logic [WORD_WIDTH-1:0]     ReadB
);

  localparam int NUM_REGS = 2 ** REG_ADDR_WIDTH;

  logic [WORD_WIDTH-1:0] regs [NUM_REGS];

  // A write strike that actually lands; address 0 is never stored.
  logic writeValid;
  assign writeValid = WriteEn && (AddrWrite != '0);

  // NOTE: this array is built from flops, not a RAM macro, so it can and must
  // be cleared by the asynchronous reset; the core relies on every register
  // reading zero right after power-on.
  always_ff @(posedge gclk or negedge PowerOn) begin
    if (!PowerOn) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regs[i] <= '0;
      end
    end else if (writeValid) begin
      // NOTE: non-blocking assignment keeps the old contents visible to the
      // combinational read ports until the edge has fully resolved.
      regs[AddrWrite] <= Write;
    end
  end

  // Read ports. Register 0 is forced to zero at the mux rather than trusting
  // the storage, so it stays hard-wired even if reg 0 were ever disturbed.
  always_comb begin
    // NOTE: defaults first so every path assigns both outputs and no latch
    // is inferred.
    ReadA = '0;
    ReadB = '0;

    if (AddrReadA != '0) begin
      ReadA = regs[AddrReadA];
`ifdef REGFILE_BYPASS_EN
      if (writeValid && (AddrReadA == AddrWrite)) begin
        ReadA = Write;
      end
`endif
    end

    if (AddrReadB != '0) begin
      ReadB = regs[AddrReadB];
`ifdef REGFILE_BYPASS_EN
      if (writeValid && (AddrReadB == AddrWrite)) begin
        ReadB = Write;
      end
`endif
    end
  end

endmodule

// File: tb/tb_risc16_reg_file.sv
`timescale 1ns/100ps
// -----------------------------------------------------------------------------
// tb_risc16_reg_file
//   Directed self-checking bench for risc16_reg_file. Inputs change just
//   after the falling edge; outputs are sampled between clock edges.
// -----------------------------------------------------------------------------
module tb_risc16_reg_file;

  localparam int WW = 16;
  localparam int AW = 3;

  logic          gclk;
  logic          PowerOn;
  logic [AW-1:0] AddrReadA;
  logic [AW-1:0] AddrReadB;
  logic [AW-1:0] AddrWrite;
  logic          WriteEn;
  logic [WW-1:0] Write;
  logic [WW-1:0] ReadA;
  logic [WW-1:0] ReadB;

  int testsRun    = 0;
  int testsFailed = 0;

  risc16_reg_file #(.WORD_WIDTH(WW), .REG_ADDR_WIDTH(AW)) dut (
    .gclk      (gclk),
    .PowerOn   (PowerOn),
    .AddrReadA (AddrReadA),
    .AddrReadB (AddrReadB),
    .AddrWrite (AddrWrite),
    .WriteEn   (WriteEn),
    .Write     (Write),
    .ReadA     (ReadA),
    .ReadB     (ReadB)
  );

  initial gclk = 1'b0;
  always #5 gclk = ~gclk;

  // One write cycle: set up after negedge, strike on posedge, then idle.
  task automatic doWrite(input logic [AW-1:0] addr, input logic [WW-1:0] data);
    @(negedge gclk);
    AddrWrite = addr;
    Write     = data;
    WriteEn   = 1'b1;
    @(posedge gclk);
    #1;
    WriteEn   = 1'b0;
  endtask

  task automatic test_reset();
    logic [WW-1:0] expZero;
    expZero = '0;
    PowerOn = 1'b0;
    // Attempted write across an edge while in reset must be dropped.
    WriteEn   = 1'b1;
    AddrWrite = 3'd4;
    Write     = 16'hDEAD;
    @(posedge gclk);
    #1;
    WriteEn = 1'b0;
    for (int i = 0; i < 8; i++) begin
      AddrReadA = AW'(i);
      AddrReadB = AW'(7 - i);
      #0.5;
      testsRun++;
      if (ReadA !== expZero) begin
        testsFailed++;
        $display("FAIL reset_readA[%0d]: got %h expected %h", i, ReadA, expZero);
      end
      testsRun++;
      if (ReadB !== expZero) begin
        testsFailed++;
        $display("FAIL reset_readB[%0d]: got %h expected %h", 7 - i, ReadB, expZero);
      end
    end
    @(negedge gclk);
    PowerOn = 1'b1;
    AddrReadA = 3'd4;
    #1;
    testsRun++;
    if (ReadA !== 16'h0000) begin
      testsFailed++;
      $display("FAIL reset_write_ignored: got %h expected %h", ReadA, 16'h0000);
    end
  endtask

  task automatic test_write_read();
    doWrite(3'd1, 16'hFFFF);
    AddrReadA = 3'd1;
    AddrReadB = 3'd1;
    #1;
    testsRun++;
    if (ReadA !== 16'hFFFF) begin
      testsFailed++;
      $display("FAIL write_read_A: got %h expected %h", ReadA, 16'hFFFF);
    end
    testsRun++;
    if (ReadB !== 16'hFFFF) begin
      testsFailed++;
      $display("FAIL write_read_B: got %h expected %h", ReadB, 16'hFFFF);
    end
  endtask

  task automatic test_r0();
    // Before the edge (bypass must not apply to address 0 either).
    @(negedge gclk);
    AddrWrite = 3'd0;
    Write     = 16'hA5A5;
    WriteEn   = 1'b1;
    AddrReadA = 3'd0;
    AddrReadB = 3'd0;
    #1;
    testsRun++;
    if (ReadA !== 16'h0000) begin
      testsFailed++;
      $display("FAIL r0_before_edge: got %h expected %h", ReadA, 16'h0000);
    end
    @(posedge gclk);
    #1;
    WriteEn = 1'b0;
    #1;
    testsRun++;
    if (ReadA !== 16'h0000) begin
      testsFailed++;
      $display("FAIL r0_after_edge_A: got %h expected %h", ReadA, 16'h0000);
    end
    testsRun++;
    if (ReadB !== 16'h0000) begin
      testsFailed++;
      $display("FAIL r0_after_edge_B: got %h expected %h", ReadB, 16'h0000);
    end
  endtask

  task automatic test_write_enable();
    @(negedge gclk);
    AddrWrite = 3'd2;
    Write     = 16'h1234;
    WriteEn   = 1'b0;
    @(posedge gclk);
    #1;
    AddrReadA = 3'd2;
    #1;
    testsRun++;
    if (ReadA !== 16'h0000) begin
      testsFailed++;
      $display("FAIL write_enable_gate: got %h expected %h", ReadA, 16'h0000);
    end
  endtask

  task automatic test_fill();
    logic [WW-1:0] expA;
    logic [WW-1:0] expB;
    for (int i = 1; i < 8; i++) begin
      doWrite(AW'(i), WW'(16'h1111 * i));
    end
    for (int i = 1; i < 8; i++) begin
      AddrReadA = AW'(i);
      AddrReadB = AW'(8 - i);
      expA = WW'(16'h1111 * i);
      expB = WW'(16'h1111 * (8 - i));
      #1;
      testsRun++;
      if (ReadA !== expA) begin
        testsFailed++;
        $display("FAIL fill_readA[%0d]: got %h expected %h", i, ReadA, expA);
      end
      testsRun++;
      if (ReadB !== expB) begin
        testsFailed++;
        $display("FAIL fill_readB[%0d]: got %h expected %h", 8 - i, ReadB, expB);
      end
    end
    // Same address on both ports.
    AddrReadA = 3'd5;
    AddrReadB = 3'd5;
    #1;
    testsRun++;
    if (ReadA !== 16'h5555 || ReadB !== 16'h5555) begin
      testsFailed++;
      $display("FAIL same_addr_both: got %h/%h expected %h", ReadA, ReadB, 16'h5555);
    end
  endtask

  task automatic test_hazard();
    logic [WW-1:0] expBefore;
`ifdef REGFILE_BYPASS_EN
    expBefore = 16'hBEEF;
`else
    expBefore = 16'h0003;
`endif
    doWrite(3'd3, 16'h0003);
    @(negedge gclk);
    AddrWrite = 3'd3;
    Write     = 16'hBEEF;
    WriteEn   = 1'b1;
    AddrReadA = 3'd3;
    AddrReadB = 3'd4;
    #1;
    testsRun++;
    if (ReadA !== expBefore) begin
      testsFailed++;
      $display("FAIL hazard_before_edge: got %h expected %h", ReadA, expBefore);
    end
    testsRun++;
    if (ReadB !== 16'h4444) begin
      testsFailed++;
      $display("FAIL hazard_other_port: got %h expected %h", ReadB, 16'h4444);
    end
    @(posedge gclk);
    #1;
    WriteEn = 1'b0;
    #1;
    testsRun++;
    if (ReadA !== 16'hBEEF) begin
      testsFailed++;
      $display("FAIL hazard_after_edge: got %h expected %h", ReadA, 16'hBEEF);
    end
  endtask

  task automatic test_reset_midrun();
    // Assert reset between edges and check everything clears with no edge.
    @(negedge gclk);
    #0.5;
    PowerOn = 1'b0;
    for (int i = 1; i < 8; i++) begin
      AddrReadA = AW'(i);
      AddrReadB = AW'(i);
      #0.3;
      testsRun++;
      if (ReadA !== 16'h0000 || ReadB !== 16'h0000) begin
        testsFailed++;
        $display("FAIL midrun_reset[%0d]: got %h/%h expected %h", i, ReadA, ReadB, 16'h0000);
      end
    end
    @(negedge gclk);
    PowerOn = 1'b1;
    AddrReadA = 3'd7;
    #1;
    testsRun++;
    if (ReadA !== 16'h0000) begin
      testsFailed++;
      $display("FAIL midrun_reset_release: got %h expected %h", ReadA, 16'h0000);
    end
  endtask

  initial begin
    PowerOn   = 1'b0;
    AddrReadA = '0;
    AddrReadB = '0;
    AddrWrite = '0;
    WriteEn   = 1'b0;
    Write     = '0;
    #2;
    test_reset();
    test_write_read();
    test_r0();
    test_write_enable();
    test_fill();
    test_hazard();
    test_reset_midrun();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
